// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// codes, FSM state encoding and the byte-lane width.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Unsigned loads have no store counterpart, so BU/HU are only legal for loads.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (!we && ((f3 == F3_BU) || (f3 == F3_HU))));
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for RV32I loads and stores: byte enables and replicated
// store data for writes, lane select plus sign/zero extension for reads.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [31:0]     wdata,
    input  logic [31:0]     rword,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata_sh,
    output logic [31:0]     rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Store side: replicate the source so every lane carries the right bits,
    // and let the byte enables pick which lanes actually get written.
    always_comb begin
        be       = '0;
        wdata_sh = '0;
        case (funct3)
            F3_B: begin
                be       = 4'b0001 << addr_lo;
                wdata_sh = {4{wdata[7:0]}};
            end
            F3_H: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{wdata[15:0]}};
            end
            F3_W: begin
                be       = 4'b1111;
                wdata_sh = wdata;
            end
            default: ;
        endcase
    end

    // Load side: select the addressed lane and extend it to 32 bits.
    always_comb begin
        rbyte = rword[{addr_lo, 3'b000} +: 8];
        rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (funct3)
            F3_B:    rdata_ext = {{24{rbyte[7]}}, rbyte};
            F3_BU:   rdata_ext = {24'd0, rbyte};
            F3_H:    rdata_ext = {{16{rhalf[15]}}, rhalf};
            F3_HU:   rdata_ext = {16'd0, rhalf};
            F3_W:    rdata_ext = rword;
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: owns the data RAM, accepts one load/store at a time,
// inserts WAIT_STATES wait cycles, then presents read data / error status
// until the core takes the response.
// Build option: define DMEM_MISALIGN_TRAP_EN to flag misaligned halfword and
// word accesses as errors; otherwise the low address bits are ignored.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; with zero wait states the access happens on accept
// WAIT  | request latched, counting down wait states; access when counter is 0
// RESP  | response presented and held until rsp_ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t state, state_nxt;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [2:0]  lat_f3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic            accept;
    logic            do_access;
    logic            acc_we;
    logic [2:0]      acc_f3;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic            acc_err;
    logic            misalign;
    logic            wr_en;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     rword;
    logic [BE_W-1:0] be;
    logic [31:0]     wdata_sh;
    logic [31:0]     rdata_ext;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        do_access = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    do_access = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // In IDLE the access (zero-wait case) uses the live request; later it
    // uses the copy latched at accept, since the core may drop the inputs.
    assign acc_we    = (state == IDLE) ? req_we     : lat_we;
    assign acc_f3    = (state == IDLE) ? req_funct3 : lat_f3;
    assign acc_addr  = (state == IDLE) ? req_addr   : lat_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata  : lat_wdata;

    assign acc_idx = acc_addr[AW+1:2];
    assign rword   = mem[acc_idx];

    // Error classification for the pending access.
    always_comb begin
        misalign = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = (((acc_f3 == F3_H) || (acc_f3 == F3_HU)) && acc_addr[0]) ||
                   ((acc_f3 == F3_W) && (acc_addr[1:0] != 2'b00));
`endif
        acc_err = f3_illegal(acc_f3, acc_we) ||
                  (acc_addr[31:2] >= 30'(DEPTH_WORDS)) ||
                  misalign;
    end

    assign wr_en = do_access && acc_we && !acc_err;

    dmem_lane u_lane (
        .funct3    (acc_f3),
        .addr_lo   (acc_addr[1:0]),
        .wdata     (acc_wdata),
        .rword     (rword),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    // Request latch, wait-state down-counter and held response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_f3    <= 3'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_f3    <= req_funct3;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt       <= CNT_INIT;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || acc_we) ? 32'd0 : rdata_ext;
            end
        end
    end

    // Data array write port; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) mem[acc_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder with a word-array reference model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int WS    = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [DEPTH];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: word array, byte arithmetic on the addressed word.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic [31:0] erd, output logic eer);
        int unsigned idx, sh, hs;
        logic [31:0] w, b, h;
        eer = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 >= 3'd4)) ||
              ((addr / 32'd4) >= 32'(DEPTH));
`ifdef DMEM_MISALIGN_TRAP_EN
        if (((f3 == 3'd1) || (f3 == 3'd5)) && ((addr % 32'd2) != 32'd0)) eer = 1'b1;
        if ((f3 == 3'd2) && ((addr % 32'd4) != 32'd0)) eer = 1'b1;
`endif
        erd = 32'd0;
        if (eer) return;
        idx = addr / 32'd4;
        sh  = (addr % 32'd4) * 32'd8;
        hs  = ((addr / 32'd2) % 32'd2) * 32'd16;
        w   = mdl[idx];
        if (we) begin
            case (f3)
                3'd0:    w = (w & ~(32'hFF << sh))   | ((wd & 32'hFF) << sh);
                3'd1:    w = (w & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
                default: w = wd;
            endcase
            mdl[idx] = w;
        end else begin
            b = (w >> sh) & 32'hFF;
            h = (w >> hs) & 32'hFFFF;
            case (f3)
                3'd0:    erd = (b >= 32'd128)   ? (b - 32'd256)   : b;
                3'd4:    erd = b;
                3'd1:    erd = (h >= 32'd32768) ? (h - 32'd65536) : h;
                3'd5:    erd = h;
                default: erd = w;
            endcase
        end
    endfunction

    // Drives one request, waits for the response, holds rsp_ready low for
    // 'hold' cycles, then completes the handshake.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er, output int lat, output int stall);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        stall = 0;
        while (!req_ready && stall < 50) begin
            @(negedge clk);
            stall++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        reset = 1'b1;
    endtask

    task automatic test_fill();
        logic [31:0] rd, erd, wd;
        logic er, eer;
        int lat, stall;
        for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom;
            model(1'b1, F3_W, 32'(i * 4), wd, erd, eer);
            txn(1'b1, F3_W, 32'(i * 4), wd, 0, rd, er, lat, stall);
            checks++; if (er !== 1'b0 || lat !== WS) begin
                errors++; $display("FAIL fill_sw[%0d]: err %b lat %0d want err 0 lat %0d", i, er, lat, WS);
            end
        end
    endtask

    // Directed sub-word sequence with literal expectations.
    task automatic test_lanes();
        logic        t_we [12];
        logic [2:0]  t_f3 [12];
        logic [31:0] t_ad [12];
        logic [31:0] t_wd [12];
        logic [31:0] t_ex [12];
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, stall;
        t_we = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        t_f3 = '{F3_W, F3_W, F3_B, F3_B, F3_BU, F3_W, F3_H, F3_H, F3_HU, F3_W, F3_B, F3_HU};
        t_ad = '{32'h10, 32'h10, 32'h13, 32'h13, 32'h13, 32'h10, 32'h12, 32'h12, 32'h12, 32'h10, 32'h10, 32'h10};
        t_wd = '{32'hDEADBEEF, 0, 32'h80, 0, 0, 0, 32'h8001, 0, 0, 0, 0, 0};
        t_ex = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hFFFFFF80, 32'h00000080, 32'h80ADBEEF,
                 32'h0, 32'hFFFF8001, 32'h00008001, 32'h8001BEEF, 32'hFFFFFFEF, 32'h0000BEEF};
        for (int i = 0; i < 12; i++) begin
            model(t_we[i], t_f3[i], t_ad[i], t_wd[i], erd, eer);
            txn(t_we[i], t_f3[i], t_ad[i], t_wd[i], 0, rd, er, lat, stall);
            checks++; if (lat !== WS) begin errors++; $display("FAIL lanes_lat[%0d]: got %0d want %0d", i, lat, WS); end
            checks++; if (er !== 1'b0) begin errors++; $display("FAIL lanes_err[%0d]: got %b want 0", i, er); end
            checks++; if (rd !== t_ex[i]) begin errors++; $display("FAIL lanes_rdata[%0d]: got %h want %h", i, rd, t_ex[i]); end
        end
    endtask

    task automatic test_misalign();
        logic        t_we [6];
        logic [2:0]  t_f3 [6];
        logic [31:0] t_ad [6];
        logic [31:0] t_wd [6];
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, stall;
        t_we = '{0, 1, 0, 0, 0, 1};
        t_f3 = '{F3_W, F3_W, F3_W, F3_H, F3_B, F3_H};
        t_ad = '{32'h11, 32'h11, 32'h10, 32'h13, 32'h11, 32'h15};
        t_wd = '{0, 32'h11111111, 0, 0, 0, 32'h0000A5C3};
        for (int i = 0; i < 6; i++) begin
            model(t_we[i], t_f3[i], t_ad[i], t_wd[i], erd, eer);
            txn(t_we[i], t_f3[i], t_ad[i], t_wd[i], 0, rd, er, lat, stall);
            checks++; if (er !== eer) begin errors++; $display("FAIL misalign_err[%0d]: got %b want %b", i, er, eer); end
            checks++; if (rd !== erd) begin errors++; $display("FAIL misalign_rdata[%0d]: got %h want %h", i, rd, erd); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, erd, dummy;
        logic er, eer, dummy_e;
        int lat, stall;
        model(1'b0, F3_W, 32'h10, 32'd0, erd, eer);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'd0;
        @(posedge clk); #1;
        req_we = 1'b1; req_wdata = 32'hAAAA5555;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_wait: got %b want 0", req_ready); end
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== WS) begin errors++; $display("FAIL bp_lat: got %0d want %0d", lat, WS); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold_valid[%0d]: valid %b ready %b want 1 0", c, rsp_valid, req_ready);
            end
            checks++; if (rsp_rdata !== erd || rsp_err !== eer) begin
                errors++; $display("FAIL bp_hold_data[%0d]: got %h/%b want %h/%b", c, rsp_rdata, rsp_err, erd, eer);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: valid %b ready %b want 0 1", rsp_valid, req_ready);
        end
        model(1'b0, F3_W, 32'h10, 32'd0, erd, eer);
        txn(1'b0, F3_W, 32'h10, 32'd0, 0, rd, er, lat, stall);
        checks++; if (rd !== erd || er !== 1'b0) begin
            errors++; $display("FAIL bp_no_store: got %h/%b want %h/0", rd, er, erd);
        end
        dummy = rd; dummy_e = er;
    endtask

    task automatic test_errors();
        logic        t_we [9];
        logic [2:0]  t_f3 [9];
        logic [31:0] t_ad [9];
        logic [31:0] t_wd [9];
        logic        t_er [9];
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, stall;
        t_we = '{0, 0, 0, 0, 1, 1, 0, 1, 0};
        t_f3 = '{F3_W, F3_W, 3'b111, 3'b011, F3_BU, F3_W, F3_W, F3_W, 3'b110};
        t_ad = '{32'(DEPTH * 4), 32'(DEPTH * 4 - 4), 32'h10, 32'h10, 32'h10, 32'(DEPTH * 4), 32'h0, 32'hFFFFFFFC, 32'h10};
        t_wd = '{0, 0, 0, 0, 32'h5A, 32'hCAFEF00D, 0, 32'h0BADF00D, 0};
        t_er = '{1, 0, 1, 1, 1, 1, 0, 1, 1};
        for (int i = 0; i < 9; i++) begin
            model(t_we[i], t_f3[i], t_ad[i], t_wd[i], erd, eer);
            txn(t_we[i], t_f3[i], t_ad[i], t_wd[i], 0, rd, er, lat, stall);
            checks++; if (er !== t_er[i]) begin errors++; $display("FAIL errors_err[%0d]: got %b want %b", i, er, t_er[i]); end
            checks++; if (rd !== erd) begin errors++; $display("FAIL errors_rdata[%0d]: got %h want %h", i, rd, erd); end
        end
        model(1'b0, F3_W, 32'h10, 32'd0, erd, eer);
        txn(1'b0, F3_W, 32'h10, 32'd0, 0, rd, er, lat, stall);
        checks++; if (rd !== erd) begin errors++; $display("FAIL errors_no_write: got %h want %h", rd, erd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, stall;
        model(1'b0, F3_W, 32'h20, 32'd0, erd, eer);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rstwait_in_wait: ready %b want 0", req_ready); end
        reset = 1'b0;
        #2;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rstwait_state: valid %b ready %b want 0 1", rsp_valid, req_ready);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        txn(1'b0, F3_W, 32'h20, 32'd0, 0, rd, er, lat, stall);
        checks++; if (rd !== erd || er !== 1'b0) begin
            errors++; $display("FAIL rstwait_old_value: got %h/%b want %h/0", rd, er, erd);
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h24; req_wdata = 32'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== WS) begin errors++; $display("FAIL rstresp_lat: got %0d want %0d", lat, WS); end
        reset = 1'b0;
        #2;
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL rstresp_discard: valid %b rdata %h err %b want 0 0 0", rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, ad, wd;
        logic [2:0] f3;
        logic we, er, eer;
        int lat, stall, hold;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom);
            f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom);
            if (!we && $urandom_range(0, 3) == 0) f3 = 3'($urandom_range(4, 5));
            ad = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 - 1));
            wd = $urandom;
            hold = $urandom_range(0, 3);
            model(we, f3, ad, wd, erd, eer);
            txn(we, f3, ad, wd, hold, rd, er, lat, stall);
            checks++; if (lat !== WS || stall !== 0) begin
                errors++; $display("FAIL rand_timing[%0d]: lat %0d stall %0d want %0d 0", i, lat, stall, WS);
            end
            checks++; if (er !== eer) begin
                errors++; $display("FAIL rand_err[%0d]: we %b f3 %0d addr %h got %b want %b", i, we, f3, ad, er, eer);
            end
            checks++; if (rd !== erd) begin
                errors++; $display("FAIL rand_rdata[%0d]: we %b f3 %0d addr %h got %h want %h", i, we, f3, ad, rd, erd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_lanes();
        test_misalign();
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
